// File: rtl/dcache_pkg.sv
// Shared types and address layout for the MEM-stage data cache.
// Holds the FSM state enum, memory latency and address field positions.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT
  } state_t;

  localparam int MEM_LAT = 20;
  localparam int ADDR_W  = 32;
  localparam int WORD_W  = 32;
  localparam int LINE_W  = 64;
  localparam int OFF_POS = 2;
  localparam int IDX_LSB = 3;

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for the direct-mapped cache: one combinational
// lookup port (hit, word), one write port (line fill or word update),
// asynchronous clear of valid bits on reset.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int NUM_SETS = 16,
  parameter int IDX_W    = $clog2(NUM_SETS),
  parameter int TAG_W    = ADDR_W - IDX_LSB - IDX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [TAG_W-1:0]  rd_tag,
  input  logic              rd_off,
  output logic              hit,
  output logic [WORD_W-1:0] rd_word,
  input  logic              we,
  input  logic              fill,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic              wr_off,
  input  logic [LINE_W-1:0] wr_line,
  input  logic [WORD_W-1:0] wr_word
);

  logic [NUM_SETS-1:0] valid;
  logic [TAG_W-1:0]    tags [NUM_SETS];
  logic [LINE_W-1:0]   data [NUM_SETS];

  assign hit     = valid[rd_idx] && (tags[rd_idx] == rd_tag);
  assign rd_word = rd_off ? data[rd_idx][63:32]
                          : data[rd_idx][31:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else if (we && fill) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag and data need no reset: they are meaningless while valid is 0.
  always_ff @(posedge clk) begin
    if (we) begin
      if (fill) begin
        data[wr_idx] <= wr_line;
        tags[wr_idx] <= wr_tag;
      end else if (wr_off) begin
        data[wr_idx][63:32] <= wr_word;
      end else begin
        data[wr_idx][31:0] <= wr_word;
      end
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache for MEM.
// Ports: pipeline load/store (mem_read_m, mem_write_m, addr_m, wdata_m,
// rdata_m, stall_m), block memory (mem_rd_req, mem_wr_req, mem_addr,
// mem_wdata, mem_rdata1/0, mem_done), hit_count/miss_count statistics.
module data_cache
  import dcache_pkg::*;
#(
  parameter int NUM_SETS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read_m,
  input  logic              mem_write_m,
  input  logic [ADDR_W-1:0] addr_m,
  input  logic [WORD_W-1:0] wdata_m,
  output logic [WORD_W-1:0] rdata_m,
  output logic              stall_m,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata1,
  input  logic [WORD_W-1:0] mem_rdata0,
  input  logic              mem_done,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_W - IDX_LSB - IDX_W;
  localparam int IDX_MSB = IDX_LSB + IDX_W - 1;
  localparam int TAG_LSB = IDX_LSB + IDX_W;

  state_t            state;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;

  logic [ADDR_W-1:0] look_addr;
  logic              hit;
  logic [WORD_W-1:0] hit_word;
  logic              we;
  logic              fill;
  logic              is_store;
  logic              is_load;
  logic              unused_bits;

  // In IDLE the lookup serves the new access; while waiting it checks
  // the latched request so a store can tell whether its line is present.
  assign look_addr = (state == IDLE) ? addr_m : req_addr;

  assign is_store = mem_write_m;
  assign is_load  = mem_read_m && !mem_write_m;

  assign fill = (state == RD_WAIT);
  assign we   = mem_done &&
                ((state == RD_WAIT) ||
                 ((state == WR_WAIT) && hit));

  assign unused_bits = ^{addr_m[1:0], req_addr[1:0]};

  dcache_array #(
    .NUM_SETS (NUM_SETS)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .rd_idx  (look_addr[IDX_MSB:IDX_LSB]),
    .rd_tag  (look_addr[ADDR_W-1:TAG_LSB]),
    .rd_off  (look_addr[OFF_POS]),
    .hit     (hit),
    .rd_word (hit_word),
    .we      (we),
    .fill    (fill),
    .wr_idx  (req_addr[IDX_MSB:IDX_LSB]),
    .wr_tag  (req_addr[ADDR_W-1:TAG_LSB]),
    .wr_off  (req_addr[OFF_POS]),
    .wr_line ({mem_rdata1, mem_rdata0}),
    .wr_word (req_wdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      req_addr   <= '0;
      req_wdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (is_store) begin
            req_addr  <= addr_m;
            req_wdata <= wdata_m;
            state     <= WR_WAIT;
          end else if (is_load) begin
            if (hit) begin
              hit_count <= hit_count + 32'd1;
            end else begin
              req_addr   <= addr_m;
              req_wdata  <= wdata_m;
              miss_count <= miss_count + 32'd1;
              state      <= RD_WAIT;
            end
          end
        end
        RD_WAIT: if (mem_done) state <= IDLE;
        WR_WAIT: if (mem_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_addr  = req_addr;
  assign mem_wdata = req_wdata;

  // Requests drop in the mem_done cycle so memory sees exactly
  // MEM_LAT request cycles.
  always_comb begin
    rdata_m    = '0;
    stall_m    = 1'b0;
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
    unique case (state)
      IDLE: begin
        if (is_store) begin
          stall_m = 1'b1;
        end else if (is_load) begin
          stall_m = !hit;
          if (hit) rdata_m = hit_word;
        end
      end
      RD_WAIT: begin
        mem_rd_req = !mem_done;
        stall_m    = !mem_done;
        if (mem_done) begin
          rdata_m = req_addr[OFF_POS] ? mem_rdata1 : mem_rdata0;
        end
      end
      WR_WAIT: begin
        mem_wr_req = !mem_done;
        stall_m    = !mem_done;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed testbench for data_cache with a 20-cycle block memory model.
// Checks reset, miss/hit timing, write-through, conflicts, mid-miss reset.
module tb_data_cache;
  import dcache_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_m;
  logic        mem_write_m;
  logic [31:0] addr_m;
  logic [31:0] wdata_m;
  logic [31:0] rdata_m;
  logic        stall_m;
  logic        mem_rd_req;
  logic        mem_wr_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata1;
  logic [31:0] mem_rdata0;
  logic        mem_done;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  logic        mdone;
  logic        inj_done;
  int          lat_cnt;
  logic [31:0] mem_store [int];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mem_done = mdone | inj_done;

  data_cache #(.NUM_SETS(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read_m (mem_read_m),
    .mem_write_m(mem_write_m),
    .addr_m     (addr_m),
    .wdata_m    (wdata_m),
    .rdata_m    (rdata_m),
    .stall_m    (stall_m),
    .mem_rd_req (mem_rd_req),
    .mem_wr_req (mem_wr_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata1 (mem_rdata1),
    .mem_rdata0 (mem_rdata0),
    .mem_done   (mem_done),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    int k;
    k = int'(a[31:2]);
    if (mem_store.exists(k)) return mem_store[k];
    return 32'hC0DE0000 | {16'h0, a[15:0]};
  endfunction

  // Memory: after MEM_LAT request cycles, pulse mem_done for one cycle.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_cnt    <= 0;
      mdone      <= 1'b0;
      mem_rdata0 <= '0;
      mem_rdata1 <= '0;
    end else if (mdone) begin
      mdone   <= 1'b0;
      lat_cnt <= 0;
    end else if (mem_rd_req || mem_wr_req) begin
      if (lat_cnt + 1 == MEM_LAT) begin
        lat_cnt <= 0;
        mdone   <= 1'b1;
        if (mem_wr_req) begin
          mem_store[int'(mem_addr[31:2])] = mem_wdata;
        end else begin
          mem_rdata0 <= rd_mem({mem_addr[31:3], 3'b000});
          mem_rdata1 <= rd_mem({mem_addr[31:3], 3'b100});
        end
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // One pipeline access held until stall_m drops.
  task automatic access(input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int stalls, output int reqs,
                        output logic [31:0] data,
                        output logic [31:0] raddr);
    bit done;
    @(negedge clk);
    mem_read_m  = rd;
    mem_write_m = wr;
    addr_m      = a;
    wdata_m     = wd;
    stalls = 0;
    reqs   = 0;
    data   = '0;
    raddr  = '0;
    done   = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (mem_rd_req || mem_wr_req) begin
        reqs++;
        raddr = mem_addr;
      end
      if (!stall_m) begin
        data = rdata_m;
        done = 1;
        break;
      end
      stalls++;
      @(negedge clk);
    end
    if (!done) chk("timeout", 32'd1, 32'd0);
    @(negedge clk);
    mem_read_m  = 1'b0;
    mem_write_m = 1'b0;
    addr_m      = '0;
    wdata_m     = '0;
  endtask

  int          st;
  int          rq;
  logic [31:0] dat;
  logic [31:0] ra;

  initial begin
    reset       = 1'b1;
    mem_read_m  = 1'b0;
    mem_write_m = 1'b0;
    addr_m      = '0;
    wdata_m     = '0;
    inj_done    = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall", {31'h0, stall_m}, 32'd0);
    chk("rst_rdata", rdata_m, 32'd0);
    chk("rst_rdreq", {31'h0, mem_rd_req}, 32'd0);
    chk("rst_wrreq", {31'h0, mem_wr_req}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_miss", miss_count, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    access(1, 0, 32'h40, 0, st, rq, dat, ra);
    chk("ld40_stall", st, 21);
    chk("ld40_req", rq, 20);
    chk("ld40_addr", ra, 32'h40);
    chk("ld40_data", dat, 32'hC0DE0040);
    chk("ld40_miss", miss_count, 1);

    access(1, 0, 32'h44, 0, st, rq, dat, ra);
    chk("ld44_stall", st, 0);
    chk("ld44_data", dat, 32'hC0DE0044);
    chk("ld44_hits", hit_count, 1);

    access(0, 1, 32'h44, 32'hDEADBEEF, st, rq, dat, ra);
    chk("st44_stall", st, 21);
    chk("st44_req", rq, 20);
    chk("st44_addr", ra, 32'h44);
    chk("st44_mem", rd_mem(32'h44), 32'hDEADBEEF);
    access(1, 0, 32'h44, 0, st, rq, dat, ra);
    chk("ld44b_stall", st, 0);
    chk("ld44b_data", dat, 32'hDEADBEEF);
    chk("ld44b_hits", hit_count, 2);

    access(0, 1, 32'h1000, 32'h12345678, st, rq, dat, ra);
    chk("st1000_stall", st, 21);
    chk("st1000_mem", rd_mem(32'h1000), 32'h12345678);
    access(1, 0, 32'h1000, 0, st, rq, dat, ra);
    chk("ld1000_stall", st, 21);
    chk("ld1000_data", dat, 32'h12345678);
    chk("ld1000_miss", miss_count, 2);

    access(1, 0, 32'h40, 0, st, rq, dat, ra);
    chk("cf40_stall", st, 0);
    chk("cf40_data", dat, 32'hC0DE0040);
    access(1, 0, 32'hC0, 0, st, rq, dat, ra);
    chk("cfC0_stall", st, 21);
    chk("cfC0_data", dat, 32'hC0DE00C0);
    access(1, 0, 32'h40, 0, st, rq, dat, ra);
    chk("cf40b_stall", st, 21);
    chk("cf40b_data", dat, 32'hC0DE0040);
    access(1, 0, 32'h44, 0, st, rq, dat, ra);
    chk("cf44_data", dat, 32'hDEADBEEF);
    chk("cf_miss", miss_count, 4);
    chk("cf_hits", hit_count, 4);

    access(1, 1, 32'h48, 32'hA5A5A5A5, st, rq, dat, ra);
    chk("rw48_stall", st, 21);
    chk("rw48_rdata", dat, 32'd0);
    chk("rw48_mem", rd_mem(32'h48), 32'hA5A5A5A5);
    chk("rw48_miss", miss_count, 4);

    @(negedge clk);
    inj_done = 1'b1;
    #1;
    chk("idle_done_stall", {31'h0, stall_m}, 32'd0);
    chk("idle_done_rdata", rdata_m, 32'd0);
    @(negedge clk);
    inj_done = 1'b0;
    #1;
    chk("idle_done_rdreq", {31'h0, mem_rd_req}, 32'd0);
    chk("idle_done_hits", hit_count, 4);

    @(negedge clk);
    mem_read_m = 1'b1;
    addr_m     = 32'h58;
    repeat (10) @(negedge clk);
    #1;
    chk("mid_rdreq_pre", {31'h0, mem_rd_req}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rdreq", {31'h0, mem_rd_req}, 32'd0);
    chk("mid_miss", miss_count, 0);
    mem_read_m = 1'b0;
    addr_m     = '0;
    #1;
    chk("mid_stall", {31'h0, stall_m}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    access(1, 0, 32'h58, 0, st, rq, dat, ra);
    chk("post_stall", st, 21);
    chk("post_data", dat, 32'hC0DE0058);
    chk("post_miss", miss_count, 1);
    chk("post_hits", hit_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-through, no-write-allocate data cache in the MEM stage, between the pipeline (load/store port) and the 20-cycle block data memory. Each line holds one 64-bit block (two 32-bit words). Read hits return data in the same cycle. A read miss fetches the whole block from memory and stalls the pipeline until it arrives. Every store goes through to memory and stalls until memory signals completion.

## Interface
- NUM_SETS, 16, number of lines (power of 2, ≥2); IDX_W = log2(NUM_SETS)
- clk  in  1  clock, all state updates on posedge
- reset  in  1  asynchronous, active-high; clears state and valid bits
- mem_read_m  in  1  load in MEM stage
- mem_write_m  in  1  store in MEM stage
- addr_m  in  32  byte address; [2] word offset, [IDX_W+2:3] index, [31:IDX_W+3] tag; [1:0] ignored
- wdata_m  in  32  store data
- rdata_m  out  32  load data
- stall_m  out  1  freeze pipeline this cycle
- mem_rd_req  out  1  block read request to memory
- mem_wr_req  out  1  word write request to memory
- mem_addr  out  32  request address (held stable while request high)
- mem_wdata  out  32  store word to memory
- mem_rdata1  in  32  fetched block upper word (offset 1)
- mem_rdata0  in  32  fetched block lower word (offset 0)
- mem_done  in  1  one-cycle completion pulse from memory
- hit_count  out  32  loads that hit
- miss_count  out  32  loads that missed

## Operation
- Storage per line: valid, tag, data[63:0]. Hit = valid[idx] && tag[idx]==addr tag.
- If mem_read_m and mem_write_m are both high, treat the cycle as a store and ignore the load.
- FSM has three states: IDLE, RD_WAIT, WR_WAIT.
- IDLE:
  - Load hit: rdata_m = selected word, stall_m=0, hit_count+1.
  - Load miss: stall_m=1, latch addr and wdata into request registers, miss_count+1, go to RD_WAIT.
  - Store: stall_m=1, latch request, go to WR_WAIT.
- RD_WAIT:
  - mem_rd_req = !mem_done.
  - stall_m = !mem_done.
  - When mem_done=1: write line {mem_rdata1, mem_rdata0}, set the tag, set valid. rdata_m bypasses from mem_rdata1 or mem_rdata0 by the latched addr[2]. Go to IDLE.
- WR_WAIT:
  - mem_wr_req = !mem_done.
  - stall_m = !mem_done.
  - When mem_done=1: if the latched address hits, write wdata into that word of the line; on a miss the line is unchanged. Go to IDLE.
- mem_addr and mem_wdata always come from the request registers.
- rdata_m = 0 when no load is completing in the current cycle.
- Requests are deasserted combinationally in the mem_done cycle, so memory never counts an extra cycle.
- Counters wrap modulo 2^32. Neither counter increments during stall re-presentation of the same load.

## Timing
- Read hit: 0 extra cycles.
- Read miss:
  - Cycle 0: IDLE detects the miss.
  - Cycles 1..20: RD_WAIT with request high.
  - Cycle 21: mem_done=1, data valid, stall_m=0. The pipeline advances at the end of cycle 21.
  - Total: 21 stall cycles with the 20-cycle memory.
- Store: same timing, 21 stall cycles.
- Line fill and the store-hit word update are visible to a load presented in the cycle after mem_done.
- Reset values: state IDLE, all valid=0, mem_rd_req=0, mem_wr_req=0, mem_addr=0, mem_wdata=0, hit_count=0, miss_count=0. stall_m=0 and rdata_m=0 while inputs are idle.
- Reset mid-miss/store: the request drops immediately, no line is written, and the state returns to IDLE. Any late mem_done is ignored in IDLE.
- mem_done in IDLE is ignored.

## Structure
- Package dcache_pkg:
  - state enum {IDLE, RD_WAIT, WR_WAIT}
  - MEM_LAT=20, used by the bench only
  - address field widths and offset positions
- Sub-module dcache_array:
  - valid/tag/data storage
  - combinational read port (hit, word)
  - one write port (full-line fill, or single-word update with a word-select)
  - asynchronous clear of valid bits
- The top level holds the FSM, request registers, counters and output muxing.

## Test plan
- Reset, then load 0x40 (cold): stall_m high 21 cycles, mem_rd_req high cycles 1–20, rdata_m = memory word at 0x40 in cycle 21, miss_count=1.
- Load 0x44 next: 0 stalls, returns the upper word of the same block, hit_count=1.
- Store 0xDEADBEEF to 0x44 (hit): 21 stall cycles, mem_wr_req with mem_addr=0x44, then load 0x44 → 0xDEADBEEF with no stall.
- Store to 0x1000 (miss): memory written, no line allocated; load 0x1000 then misses (miss_count increments).
- Conflict: load 0x40, then 0x40+8*NUM_SETS (same index): second misses and evicts the line; reloading 0x40 misses again.
- Assert reset at cycle 10 of a read miss: mem_rd_req drops immediately, state returns to IDLE, valid stays 0; a following load of the same address misses.
